// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_LOCK_TIMEOUT = 16;

  // Round-robin successor of index k among n requesters.
  function automatic int next_ptr(input int k, input int n);
    if (k + 1 >= n) return 0;
    return k + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after start, wrapping.
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] winner
);

  localparam logic [IDX_W:0] N_W = (IDX_W+1)'(N);

  logic [IDX_W:0] pos;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    pos    = '0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, start} + (IDX_W+1)'(i);
      if (pos >= N_W) pos = pos - N_W;
      if (!found && req[pos[IDX_W-1:0]]) begin
        found  = 1'b1;
        winner = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the TX FIFO write port, with locked multi-beat frames.
// Handshake: a beat moves on a rising edge where ack[k]=1; ack/wdata/w_inc are combinational from req.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ      = 2,
  parameter  int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter  int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  localparam int IDX_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          w_clk,
  input  logic                          w_rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            lock,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          wfull,
  output logic [NUM_REQ-1:0]            ack,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic                          w_inc,
  output logic [IDX_W-1:0]              grant_id,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int                TCNT_W    = $clog2(LOCK_TIMEOUT) + 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [TCNT_W-1:0] TCNT_MAX  = '1;

  arb_state_t        state, state_n;
  logic [IDX_W-1:0]  prio_ptr, prio_n;
  logic [IDX_W-1:0]  owner, owner_n;
  logic [TCNT_W-1:0] tcnt, tcnt_n;
  logic              terr_n;

  logic              found;
  logic [IDX_W-1:0]  winner;
  logic              grant;
  logic [IDX_W-1:0]  gid;

  rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req    (req),
    .start  (prio_ptr),
    .found  (found),
    .winner (winner)
  );

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state       <= ARB_IDLE;
      prio_ptr    <= '0;
      owner       <= '0;
      tcnt        <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      prio_ptr    <= prio_n;
      owner       <= owner_n;
      tcnt        <= tcnt_n;
      timeout_err <= terr_n;
    end
  end

  always_comb begin
    state_n = state;
    prio_n  = prio_ptr;
    owner_n = owner;
    tcnt_n  = tcnt;
    terr_n  = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (grant) begin
          prio_n = IDX_W'(next_ptr(int'(gid), NUM_REQ));
          if (lock[gid]) begin
            state_n = ARB_LOCKED;
            owner_n = gid;
            tcnt_n  = '0;
          end
        end
      end
      ARB_LOCKED: begin
        if (grant) begin
          prio_n = IDX_W'(next_ptr(int'(gid), NUM_REQ));
          tcnt_n = '0;
          if (!lock[owner]) state_n = ARB_IDLE;
        end else if (!req[owner]) begin
          // Only true idleness counts; a stalled owner keeps its lock indefinitely.
          if (tcnt == TCNT_LAST) begin
            state_n = ARB_IDLE;
            terr_n  = 1'b1;
            tcnt_n  = '0;
          end else if (tcnt != TCNT_MAX) begin
            tcnt_n = tcnt + 1'b1;
          end
        end
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  always_comb begin
    grant = 1'b0;
    gid   = '0;
    if (!w_rst) begin
      case (state)
        ARB_IDLE:   if (!wfull && found)      begin grant = 1'b1; gid = winner; end
        ARB_LOCKED: if (!wfull && req[owner]) begin grant = 1'b1; gid = owner;  end
        default:    ;
      endcase
    end
    ack   = '0;
    wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant && gid == IDX_W'(k)) begin
        ack[k] = 1'b1;
        wdata  = req_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    w_inc    = grant;
    grant_id = gid;
    busy     = (state == ARB_LOCKED) && !w_rst;
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (2 requesters, 8-bit data, 16-cycle lock timeout).
module tb_fifo_wr_arbiter;

  logic       clk;
  logic       w_rst;
  logic [1:0] req;
  logic [1:0] lock;
  logic [7:0] d0, d1;
  logic       wfull;
  logic [1:0] ack;
  logic [7:0] wdata;
  logic       w_inc;
  logic [0:0] grant_id;
  logic       busy;
  logic       timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  fifo_wr_arbiter #(.NUM_REQ(2), .DATA_WIDTH(8), .LOCK_TIMEOUT(16)) dut (
    .w_clk       (clk),
    .w_rst       (w_rst),
    .req         (req),
    .lock        (lock),
    .req_data    ({d1, d0}),
    .wfull       (wfull),
    .ack         (ack),
    .wdata       (wdata),
    .w_inc       (w_inc),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Check all outputs at the falling edge, then advance to just after the next rising edge.
  task automatic cyc(input string tag, input logic inc, input logic [1:0] a, input logic [7:0] wd,
                     input logic gid, input logic b, input logic terr);
    @(negedge clk);
    chk({tag, ".w_inc"}, 32'(w_inc), 32'(inc));
    chk({tag, ".ack"}, 32'(ack), 32'(a));
    chk({tag, ".wdata"}, 32'(wdata), 32'(wd));
    chk({tag, ".grant_id"}, 32'(grant_id), 32'(gid));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".timeout_err"}, 32'(timeout_err), 32'(terr));
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic [1:0] r, input logic [1:0] l,
                       input logic f, input logic [7:0] a, input logic [7:0] b);
    w_rst = rst; req = r; lock = l; wfull = f; d0 = a; d1 = b;
  endtask

  initial begin
    // Reset with both requesting: every output must stay quiet.
    drive(1'b1, 2'b11, 2'b00, 1'b0, 8'h11, 8'h22);
    @(posedge clk); #1;
    cyc("rst0", 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc("rst1", 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);

    // Both requesting, no lock: strict alternation starting at index 0.
    drive(1'b0, 2'b11, 2'b00, 1'b0, 8'h11, 8'h22);
    cyc("rr0", 1'b1, 2'b01, 8'h11, 1'b0, 1'b0, 1'b0);
    cyc("rr1", 1'b1, 2'b10, 8'h22, 1'b1, 1'b0, 1'b0);
    cyc("rr2", 1'b1, 2'b01, 8'h11, 1'b0, 1'b0, 1'b0);
    cyc("rr3", 1'b1, 2'b10, 8'h22, 1'b1, 1'b0, 1'b0);

    // Locked 3-beat frame from requester 0 while requester 1 keeps asking.
    drive(1'b0, 2'b11, 2'b01, 1'b0, 8'hA1, 8'h22);
    cyc("lk_b1", 1'b1, 2'b01, 8'hA1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 2'b11, 2'b01, 1'b0, 8'hA2, 8'h22);
    cyc("lk_b2", 1'b1, 2'b01, 8'hA2, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 2'b11, 2'b00, 1'b0, 8'hA3, 8'h22);
    cyc("lk_b3", 1'b1, 2'b01, 8'hA3, 1'b0, 1'b1, 1'b0);
    cyc("lk_rel", 1'b1, 2'b10, 8'h22, 1'b1, 1'b0, 1'b0);

    // FIFO full for 5 cycles, then grant resumes at the pre-stall pointer (0).
    drive(1'b0, 2'b11, 2'b00, 1'b1, 8'h11, 8'h22);
    for (int i = 0; i < 5; i++) cyc("full", 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
    wfull = 1'b0;
    cyc("full_end", 1'b1, 2'b01, 8'h11, 1'b0, 1'b0, 1'b0);

    // Lock by requester 0 (pointer at 1, req1 low), then owner goes idle.
    drive(1'b0, 2'b01, 2'b01, 1'b0, 8'hA5, 8'h22);
    cyc("to_lock", 1'b1, 2'b01, 8'hA5, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 2'b10, 2'b00, 1'b0, 8'h00, 8'h22);
    for (int i = 0; i < 16; i++) cyc("to_wait", 1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc("to_fire", 1'b1, 2'b10, 8'h22, 1'b1, 1'b0, 1'b1);
    req = 2'b00;
    cyc("to_after", 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);

    // Owner stalled by wfull for 40 cycles keeps its lock with no timeout.
    drive(1'b0, 2'b01, 2'b01, 1'b0, 8'hB1, 8'h22);
    cyc("st_lock", 1'b1, 2'b01, 8'hB1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 2'b11, 2'b01, 1'b1, 8'hB2, 8'h22);
    for (int i = 0; i < 40; i++) cyc("st_hold", 1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 2'b11, 2'b00, 1'b0, 8'hB2, 8'h22);
    cyc("st_resume", 1'b1, 2'b01, 8'hB2, 1'b0, 1'b1, 1'b0);
    cyc("st_rel", 1'b1, 2'b10, 8'h22, 1'b1, 1'b0, 1'b0);

    // Reset mid-frame: lock abandoned and pointer back to 0.
    drive(1'b0, 2'b01, 2'b01, 1'b0, 8'hC1, 8'h22);
    cyc("mr_lock", 1'b1, 2'b01, 8'hC1, 1'b0, 1'b0, 1'b0);
    req = 2'b00;
    cyc("mr_busy", 1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 2'b11, 2'b11, 1'b0, 8'hC2, 8'h22);
    cyc("mr_rst", 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 2'b11, 2'b00, 1'b0, 8'hC3, 8'h22);
    cyc("mr_post0", 1'b1, 2'b01, 8'hC3, 1'b0, 1'b0, 1'b0);
    req = 2'b10;
    cyc("mr_post1", 1'b1, 2'b10, 8'h22, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
